pipe_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core. It gathers stall requests from ID, EX and MEM, redirect requests from EX and traps, and drives per-stage stall and flush vectors to PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It owns the EX multi-cycle countdown, the pending-redirect latch and the optional MEM bus-wait watchdog.

---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush/redirect sequencer for the five-stage core.
// Collects stall requests from ID, EX (multi-cycle countdown) and MEM, plus
// branch and trap redirects, and drives per-stage stall/flush vectors.
// Optional MEM bus-wait watchdog is compiled in with PIPE_CTRL_WATCHDOG_EN.
// Vector bit mapping: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 reserved.

module pipe_ctrl #(
  parameter int EX_CNT_W       = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PC_WIDTH       = 32
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                id_stall_req_in,
  input  logic                ex_mc_start_in,
  input  logic [EX_CNT_W-1:0] ex_mc_cycles_in,
  input  logic                mem_stall_req_in,
  input  logic                branch_taken_in,
  input  logic [PC_WIDTH-1:0] branch_target_in,
  input  logic                trap_in,
  input  logic [PC_WIDTH-1:0] trap_vector_in,
  output logic [5:0]          stall_out,
  output logic [5:0]          flush_out,
  output logic                redirect_valid_out,
  output logic [PC_WIDTH-1:0] redirect_pc_out,
  output logic                bus_timeout_out
);

  // STALL: an EX countdown is in flight. REDIRECT_PENDING: the branch
  // latch holds a target waiting for the MEM stall to drop.
  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    STALL            = 2'd1,
    REDIRECT_PENDING = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [EX_CNT_W-1:0] cnt;
  logic [EX_CNT_W-1:0] cnt_next;
  logic [PC_WIDTH-1:0] pend_pc;
  logic [PC_WIDTH-1:0] pend_pc_next;

  logic timeout;
  logic ex_start;
  logic ex_stall;
  logic trap_any;
  logic pend_full;
  logic pend_issue;
  logic pend_load;

  // The watchdog counter is 8 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("pipe_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef PIPE_CTRL_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic [8:0] wd_inc;

  // Timeout fires in the stall cycle that brings the count up to the limit.
  assign wd_inc  = {1'b0, wd_cnt} + 9'd1;
  assign timeout = mem_stall_req_in && (wd_inc == 9'(TIMEOUT_CYCLES));

  // Count consecutive MEM-stall cycles; any gap, trap or timeout restarts it.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      wd_cnt <= '0;
    end else if (trap_in || timeout || !mem_stall_req_in) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_inc[7:0];
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A start is only honoured with a non-zero length and an idle counter.
  // The counter holds the stall cycles remaining after the current one, so
  // the start cycle itself stalls and the load value is N-1.
  assign ex_start   = ex_mc_start_in && (ex_mc_cycles_in != '0) && (cnt == '0);
  assign ex_stall   = ex_start || (cnt != '0);
  assign trap_any   = trap_in || timeout;
  assign pend_full  = (state == REDIRECT_PENDING);
  assign pend_issue = pend_full && !mem_stall_req_in && !trap_any;
  assign pend_load  = branch_taken_in && mem_stall_req_in && !pend_full && !trap_any;

  // Registered state: countdown, pending-redirect latch and status state.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_pc <= pend_pc_next;
    end
  end

  // Next-state: countdown keeps running under a MEM stall; traps wipe it all.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_pc_next = pend_pc;
    if (trap_any) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      if (ex_start) begin
        cnt_next = ex_mc_cycles_in - EX_CNT_W'(1);
      end else if (cnt != '0) begin
        cnt_next = cnt - EX_CNT_W'(1);
      end
      if (pend_load) begin
        pend_pc_next = branch_target_in;
      end
      if (pend_load || (pend_full && !pend_issue)) begin
        state_next = REDIRECT_PENDING;
      end else if (cnt_next != '0) begin
        state_next = STALL;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Outputs by priority: reset, trap, pending branch, live branch, stall level.
  always_comb begin
    stall_out          = 6'b000000;
    flush_out          = 6'b000000;
    redirect_valid_out = 1'b0;
    redirect_pc_out    = '0;
    bus_timeout_out    = 1'b0;
    if (!reset_n_in) begin
      flush_out = 6'b011110;
    end else if (trap_any) begin
      flush_out          = 6'b011110;
      redirect_valid_out = 1'b1;
      redirect_pc_out    = trap_vector_in;
      bus_timeout_out    = timeout;
    end else if (pend_issue) begin
      flush_out          = 6'b000110;
      redirect_valid_out = 1'b1;
      redirect_pc_out    = pend_pc;
    end else if (branch_taken_in && !mem_stall_req_in) begin
      flush_out          = 6'b000110;
      redirect_valid_out = 1'b1;
      redirect_pc_out    = branch_target_in;
    end else if (mem_stall_req_in) begin
      stall_out = 6'b001111;
    end else if (ex_stall) begin
      stall_out = 6'b000111;
      flush_out = 6'b001000;
    end else if (id_stall_req_in) begin
      stall_out = 6'b000011;
      flush_out = 6'b000100;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Builds with or without PIPE_CTRL_WATCHDOG_EN; watchdog limit is set to 4.

module tb_pipe_ctrl;

  localparam int EX_CNT_W   = 6;
  localparam int PC_WIDTH   = 32;
  localparam int TB_TIMEOUT = 4;
`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam int BR_STALL_CYCLES = 3;
`else
  localparam int BR_STALL_CYCLES = 4;
`endif

  logic                clk_in;
  logic                reset_n_in;
  logic                id_stall_req_in;
  logic                ex_mc_start_in;
  logic [EX_CNT_W-1:0] ex_mc_cycles_in;
  logic                mem_stall_req_in;
  logic                branch_taken_in;
  logic [PC_WIDTH-1:0] branch_target_in;
  logic                trap_in;
  logic [PC_WIDTH-1:0] trap_vector_in;
  logic [5:0]          stall_out;
  logic [5:0]          flush_out;
  logic                redirect_valid_out;
  logic [PC_WIDTH-1:0] redirect_pc_out;
  logic                bus_timeout_out;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .EX_CNT_W      (EX_CNT_W),
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .PC_WIDTH      (PC_WIDTH)
  ) dut (
    .clk_in            (clk_in),
    .reset_n_in        (reset_n_in),
    .id_stall_req_in   (id_stall_req_in),
    .ex_mc_start_in    (ex_mc_start_in),
    .ex_mc_cycles_in   (ex_mc_cycles_in),
    .mem_stall_req_in  (mem_stall_req_in),
    .branch_taken_in   (branch_taken_in),
    .branch_target_in  (branch_target_in),
    .trap_in           (trap_in),
    .trap_vector_in    (trap_vector_in),
    .stall_out         (stall_out),
    .flush_out         (flush_out),
    .redirect_valid_out(redirect_valid_out),
    .redirect_pc_out   (redirect_pc_out),
    .bus_timeout_out   (bus_timeout_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_in);
  endtask

  task automatic drive_idle();
    reset_n_in       = 1'b1;
    id_stall_req_in  = 1'b0;
    ex_mc_start_in   = 1'b0;
    ex_mc_cycles_in  = '0;
    mem_stall_req_in = 1'b0;
    branch_taken_in  = 1'b0;
    branch_target_in = '0;
    trap_in          = 1'b0;
    trap_vector_in   = 32'h0000_0080;
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n_in       = 1'b0;
    id_stall_req_in  = 1'b1;
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0000_0044;
    ex_mc_start_in   = 1'b1;
    ex_mc_cycles_in  = 6'd3;
    next_cycle();
    next_cycle();
    settle();
    checks++;
    if (stall_out !== 6'b000000) begin errors++; $display("[TB] FAIL reset_stall: got %b want %b", stall_out, 6'b000000); end
    checks++;
    if (flush_out !== 6'b011110) begin errors++; $display("[TB] FAIL reset_flush: got %b want %b", flush_out, 6'b011110); end
    checks++;
    if (redirect_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", redirect_valid_out); end
    checks++;
    if (redirect_pc_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", redirect_pc_out); end
    checks++;
    if (bus_timeout_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b want 0", bus_timeout_out); end
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (stall_out !== 6'b000000 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL post_reset: stall %b flush %b want 000000 000000", stall_out, flush_out);
    end
    checks++;
    if (redirect_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %b want 0", redirect_valid_out); end
    next_cycle();
  endtask

  task automatic test_reset_mid_countdown();
    drive_idle();
    ex_mc_start_in  = 1'b1;
    ex_mc_cycles_in = 6'd5;
    settle();
    checks++;
    if (stall_out !== 6'b000111) begin errors++; $display("[TB] FAIL rmc_t0_stall: got %b want 000111", stall_out); end
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (stall_out !== 6'b000111) begin errors++; $display("[TB] FAIL rmc_t1_stall: got %b want 000111", stall_out); end
    next_cycle();
    reset_n_in = 1'b0;
    settle();
    checks++;
    if (stall_out !== 6'b000000 || flush_out !== 6'b011110) begin
      errors++; $display("[TB] FAIL rmc_in_reset: stall %b flush %b want 000000 011110", stall_out, flush_out);
    end
    next_cycle();
    reset_n_in = 1'b1;
    settle();
    checks++;
    if (stall_out !== 6'b000000 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL rmc_after: stall %b flush %b want 000000 000000", stall_out, flush_out);
    end
    next_cycle();
  endtask

  task automatic test_ex_multicycle();
    drive_idle();
    for (int c = 0; c < 5; c++) begin
      ex_mc_start_in  = (c == 0) || (c == 1);
      ex_mc_cycles_in = (c == 0) ? 6'd3 : 6'd7;
      settle();
      checks++;
      if (c < 3) begin
        if (stall_out !== 6'b000111 || flush_out !== 6'b001000) begin
          errors++; $display("[TB] FAIL ex_n3_c%0d: stall %b flush %b want 000111 001000", c, stall_out, flush_out);
        end
      end else begin
        if (stall_out !== 6'b000000 || flush_out !== 6'b000000) begin
          errors++; $display("[TB] FAIL ex_n3_c%0d: stall %b flush %b want 000000 000000", c, stall_out, flush_out);
        end
      end
      next_cycle();
    end
    ex_mc_start_in  = 1'b1;
    ex_mc_cycles_in = 6'd0;
    settle();
    checks++;
    if (stall_out !== 6'b000000 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL ex_n0: stall %b flush %b want 000000 000000", stall_out, flush_out);
    end
    next_cycle();
    ex_mc_cycles_in = 6'd1;
    settle();
    checks++;
    if (stall_out !== 6'b000111) begin errors++; $display("[TB] FAIL ex_n1_c0: got %b want 000111", stall_out); end
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (stall_out !== 6'b000000) begin errors++; $display("[TB] FAIL ex_n1_c1: got %b want 000000", stall_out); end
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      ex_mc_start_in   = (c == 0);
      ex_mc_cycles_in  = 6'd3;
      mem_stall_req_in = (c == 1) || (c == 2);
      settle();
      checks++;
      case (c)
        0: if (stall_out !== 6'b000111 || flush_out !== 6'b001000) begin
             errors++; $display("[TB] FAIL ex_mem_c0: stall %b flush %b want 000111 001000", stall_out, flush_out);
           end
        1, 2: if (stall_out !== 6'b001111 || flush_out !== 6'b000000) begin
             errors++; $display("[TB] FAIL ex_mem_c%0d: stall %b flush %b want 001111 000000", c, stall_out, flush_out);
           end
        default: if (stall_out !== 6'b000000 || flush_out !== 6'b000000) begin
             errors++; $display("[TB] FAIL ex_mem_c3: stall %b flush %b want 000000 000000", stall_out, flush_out);
           end
      endcase
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_stall_levels();
    drive_idle();
    id_stall_req_in = 1'b1;
    settle();
    checks++;
    if (stall_out !== 6'b000011 || flush_out !== 6'b000100) begin
      errors++; $display("[TB] FAIL lvl_id: stall %b flush %b want 000011 000100", stall_out, flush_out);
    end
    next_cycle();
    mem_stall_req_in = 1'b1;
    settle();
    checks++;
    if (stall_out !== 6'b001111 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL lvl_id_mem: stall %b flush %b want 001111 000000", stall_out, flush_out);
    end
    next_cycle();
    id_stall_req_in = 1'b0;
    settle();
    checks++;
    if (stall_out !== 6'b001111 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL lvl_mem: stall %b flush %b want 001111 000000", stall_out, flush_out);
    end
    next_cycle();
    drive_idle();
    id_stall_req_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ex_mc_start_in  = (c == 0);
      ex_mc_cycles_in = 6'd2;
      settle();
      checks++;
      if (c < 2) begin
        if (stall_out !== 6'b000111 || flush_out !== 6'b001000) begin
          errors++; $display("[TB] FAIL lvl_ex_id_c%0d: stall %b flush %b want 000111 001000", c, stall_out, flush_out);
        end
      end else begin
        if (stall_out !== 6'b000011 || flush_out !== 6'b000100) begin
          errors++; $display("[TB] FAIL lvl_ex_id_c%0d: stall %b flush %b want 000011 000100", c, stall_out, flush_out);
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_branch();
    drive_idle();
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0000_0200;
    settle();
    checks++;
    if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 32'h0000_0200 || flush_out !== 6'b000110 || stall_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL br_direct: valid %b pc %h flush %b stall %b want 1 00000200 000110 000000",
                         redirect_valid_out, redirect_pc_out, flush_out, stall_out);
    end
    next_cycle();
    for (int c = 0; c < BR_STALL_CYCLES; c++) begin
      mem_stall_req_in = 1'b1;
      branch_taken_in  = 1'b1;
      branch_target_in = (c == 0) ? 32'h0000_0100 : 32'h0000_0999;
      settle();
      checks++;
      if (redirect_valid_out !== 1'b0 || stall_out !== 6'b001111 || flush_out !== 6'b000000) begin
        errors++; $display("[TB] FAIL br_hold_c%0d: valid %b stall %b flush %b want 0 001111 000000",
                           c, redirect_valid_out, stall_out, flush_out);
      end
      next_cycle();
    end
    drive_idle();
    settle();
    checks++;
    if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 32'h0000_0100 || flush_out !== 6'b000110 || stall_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL br_issue: valid %b pc %h flush %b stall %b want 1 00000100 000110 000000",
                         redirect_valid_out, redirect_pc_out, flush_out, stall_out);
    end
    next_cycle();
    settle();
    checks++;
    if (redirect_valid_out !== 1'b0 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL br_after: valid %b flush %b want 0 000000", redirect_valid_out, flush_out);
    end
    next_cycle();
  endtask

  task automatic test_trap();
    drive_idle();
    trap_in          = 1'b1;
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0000_0300;
    settle();
    checks++;
    if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 32'h0000_0080 || flush_out !== 6'b011110 || stall_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL trap_vs_branch: valid %b pc %h flush %b stall %b want 1 00000080 011110 000000",
                         redirect_valid_out, redirect_pc_out, flush_out, stall_out);
    end
    next_cycle();
    drive_idle();
    mem_stall_req_in = 1'b1;
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0000_0100;
    next_cycle();
    branch_taken_in = 1'b0;
    trap_in         = 1'b1;
    settle();
    checks++;
    if (redirect_pc_out !== 32'h0000_0080 || flush_out !== 6'b011110 || stall_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL trap_in_mem: pc %h flush %b stall %b want 00000080 011110 000000",
                         redirect_pc_out, flush_out, stall_out);
    end
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (redirect_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL trap_latch_clr: valid %b want 0", redirect_valid_out); end
    next_cycle();
    ex_mc_start_in  = 1'b1;
    ex_mc_cycles_in = 6'd4;
    next_cycle();
    drive_idle();
    trap_in = 1'b1;
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (stall_out !== 6'b000000) begin errors++; $display("[TB] FAIL trap_cnt_clr: stall %b want 000000", stall_out); end
    next_cycle();
  endtask

  task automatic test_reset_pending();
    drive_idle();
    mem_stall_req_in = 1'b1;
    branch_taken_in  = 1'b1;
    branch_target_in = 32'h0000_0140;
    next_cycle();
    branch_taken_in = 1'b0;
    reset_n_in      = 1'b0;
    next_cycle();
    drive_idle();
    settle();
    checks++;
    if (redirect_valid_out !== 1'b0 || flush_out !== 6'b000000) begin
      errors++; $display("[TB] FAIL rst_pending: valid %b flush %b want 0 000000", redirect_valid_out, flush_out);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    logic exp_pulse;
    drive_idle();
    trap_vector_in = 32'h0000_0080;
    next_cycle();
    for (int k = 1; k <= 10; k++) begin
      mem_stall_req_in = 1'b1;
`ifdef PIPE_CTRL_WATCHDOG_EN
      exp_pulse = ((k % TB_TIMEOUT) == 0);
`else
      exp_pulse = 1'b0;
`endif
      settle();
      checks++;
      if (bus_timeout_out !== exp_pulse || redirect_valid_out !== exp_pulse ||
          redirect_pc_out !== (exp_pulse ? 32'h0000_0080 : 32'h0) ||
          stall_out !== (exp_pulse ? 6'b000000 : 6'b001111) ||
          flush_out !== (exp_pulse ? 6'b011110 : 6'b000000)) begin
        errors++; $display("[TB] FAIL wd_k%0d: timeout %b valid %b pc %h stall %b flush %b want pulse=%b",
                           k, bus_timeout_out, redirect_valid_out, redirect_pc_out, stall_out, flush_out, exp_pulse);
      end
      next_cycle();
    end
    mem_stall_req_in = 1'b0;
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      mem_stall_req_in = 1'b1;
      settle();
      checks++;
      if (bus_timeout_out !== 1'b0 || stall_out !== 6'b001111) begin
        errors++; $display("[TB] FAIL wd_restart_k%0d: timeout %b stall %b want 0 001111", k, bus_timeout_out, stall_out);
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  initial begin
    drive_idle();
    reset_n_in = 1'b0;
    $display("[TB] pipe_ctrl directed tests starting");
    test_reset();
    test_reset_mid_countdown();
    test_ex_multicycle();
    test_stall_levels();
    test_branch();
    test_trap();
    test_reset_pending();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
